seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed BCD-to-7-segment driver for an N-digit common-anode/cathode display. Holds a double-buffered digit image, scans one digit per refresh slot with an anti-ghosting blanking gap, and supports leading-zero blanking and per-digit decimal points. It sits between the datapath, which produces BCD digits, and the board's segment/anode pins.

---
 rtl/seg7_scan_driver.sv | 157 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed BCD to 7-segment scan driver.
// A double-buffered digit image is shown one digit per slot. Each slot opens
// with an anode blanking gap. Leading zeros can be blanked, and each digit
// has its own decimal point. All pin outputs are registered.

module seg7_decode (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  // Active-high gfedcba glyph; non-decimal codes stay dark
  always_comb begin
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end
endmodule

module seg7_scan_driver #(
  parameter int N_DIGITS       = 4,
  parameter int DIV            = 50000,
  parameter int GAP            = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*N_DIGITS-1:0]   bcd_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_tick,
  output logic                    pending
);
  localparam int CW = $clog2(DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] DIG_LAST  = IW'(N_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [N_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? '1 : '0;

  logic [CW-1:0]                slot_cnt;
  logic [IW-1:0]                digit_idx;
  logic [N_DIGITS-1:0][3:0]     stg_bcd, dsp_bcd;
  logic [N_DIGITS-1:0]          stg_dp, dsp_dp;
  logic                         stg_lz, dsp_lz;

  logic                         slot_end, frame_wrap, in_gap;
  logic [N_DIGITS-1:0][6:0]     glyph;
  logic [N_DIGITS-1:0]          blank;
  logic [6:0]                   cur_seg;
  logic                         cur_dp;
  logic [N_DIGITS-1:0]          cur_an;

  assign slot_end   = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_end && (digit_idx == DIG_LAST);

  // Anode gap at the head of every slot; a zero-length gap never blanks
  if (GAP == 0) begin : g_nogap
    assign in_gap = 1'b0;
  end else begin : g_gap
    assign in_gap = (slot_cnt < CW'(GAP));
  end

  // One decoder per displayed digit, fed from the display image
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_dig
    seg7_decode u_dec (
      .bcd (dsp_bcd[k]),
      .seg (glyph[k])
    );
  end

  // Leading-zero run from the top digit down; digit 0 always shows and
  // any non-zero code (including invalid ones) ends the run
  always_comb begin : blank_run
    logic run;
    run   = dsp_lz;
    blank = '0;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      run      = run && (dsp_bcd[k] == 4'd0);
      blank[k] = run;
    end
  end

  // Pick glyph, dp and anode for the digit currently being scanned
  always_comb begin
    cur_seg = 7'h00;
    cur_dp  = 1'b0;
    cur_an  = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (digit_idx == IW'(k)) begin
        cur_seg   = blank[k] ? 7'h00 : glyph[k];
        cur_dp    = dsp_dp[k];
        cur_an[k] = ~in_gap;
      end
    end
  end

  // Scan counters, staging/display double buffer and registered pin drive.
  // The display image only changes on the frame wrap, so a frame never tears;
  // a load on the wrap cycle goes straight through to the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt   <= '0;
      digit_idx  <= '0;
      stg_bcd    <= '0;
      stg_dp     <= '0;
      stg_lz     <= 1'b0;
      dsp_bcd    <= '0;
      dsp_dp     <= '0;
      dsp_lz     <= 1'b0;
      pending    <= 1'b0;
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end)
        digit_idx <= (digit_idx == DIG_LAST) ? '0 : digit_idx + 1'b1;

      if (load) begin
        stg_bcd <= bcd_in;
        stg_dp  <= dp_in;
        stg_lz  <= lz_blank;
      end

      if (frame_wrap) begin
        dsp_bcd <= load ? bcd_in   : stg_bcd;
        dsp_dp  <= load ? dp_in    : stg_dp;
        dsp_lz  <= load ? lz_blank : stg_lz;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end

      seg        <= SEG_ACTIVE_LOW ? ~cur_seg : cur_seg;
      dp         <= cur_dp ^ SEG_ACTIVE_LOW;
      an         <= AN_ACTIVE_LOW ? ~cur_an : cur_an;
      frame_tick <= (slot_cnt == '0) && (digit_idx == '0);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: three instances (4 digits, 1 digit, 8 digits
// with no gap and active-high pins) all run against a frame/time based
// reference model, plus directed table vectors on the 4-digit instance.

module tb_seg7_scan_driver;

  typedef struct packed {
    logic [15:0]     bcd;
    logic [3:0]      dpi;
    logic            lz;
    logic [3:0][6:0] eseg;   // expected seg pins, digit k in [k]
    logic [3:0]      edp;    // expected dp pins
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [31:0] s_bcd  [3];
  logic [7:0]  s_dp   [3];
  logic        s_lz   [3];
  logic        s_load [3];

  logic [15:0] bcd0; logic [3:0] dp0i; logic [6:0] seg0; logic dp0; logic [3:0] an0; logic ft0, pend0;
  logic [3:0]  bcd1; logic [0:0] dp1i; logic [6:0] seg1; logic dp1; logic [0:0] an1; logic ft1, pend1;
  logic [31:0] bcd2; logic [7:0] dp2i; logic [6:0] seg2; logic dp2; logic [7:0] an2; logic ft2, pend2;

  assign bcd0 = s_bcd[0][15:0]; assign dp0i = s_dp[0][3:0];
  assign bcd1 = s_bcd[1][3:0];  assign dp1i = s_dp[1][0:0];
  assign bcd2 = s_bcd[2];       assign dp2i = s_dp[2];

  seg7_scan_driver #(.N_DIGITS(4), .DIV(8), .GAP(2), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u0 (
    .clk(clk), .rst(rst), .bcd_in(bcd0), .dp_in(dp0i), .lz_blank(s_lz[0]), .load(s_load[0]),
    .seg(seg0), .dp(dp0), .an(an0), .frame_tick(ft0), .pending(pend0));
  seg7_scan_driver #(.N_DIGITS(1), .DIV(4), .GAP(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u1 (
    .clk(clk), .rst(rst), .bcd_in(bcd1), .dp_in(dp1i), .lz_blank(s_lz[1]), .load(s_load[1]),
    .seg(seg1), .dp(dp1), .an(an1), .frame_tick(ft1), .pending(pend1));
  seg7_scan_driver #(.N_DIGITS(8), .DIV(4), .GAP(0), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u2 (
    .clk(clk), .rst(rst), .bcd_in(bcd2), .dp_in(dp2i), .lz_blank(s_lz[2]), .load(s_load[2]),
    .seg(seg2), .dp(dp2), .an(an2), .frame_tick(ft2), .pending(pend2));

  int pn  [3] = '{4, 1, 8};
  int pdv [3] = '{8, 4, 4};
  int pgp [3] = '{2, 1, 0};
  bit psl [3] = '{1'b1, 1'b1, 1'b0};
  bit pal [3] = '{1'b1, 1'b1, 1'b0};

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  // reference model state: t = cycles elapsed in the current run since reset
  int          m_t    [3];
  logic [31:0] m_sb   [3], m_db [3];
  logic [7:0]  m_sd   [3], m_dd [3];
  logic        m_sl   [3], m_dl [3], m_pend [3];
  logic [6:0]  m_seg  [3];
  logic        m_dp   [3], m_ft [3];
  logic [7:0]  m_an   [3];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int gap0_viol = 0;
  logic last_rst;

  function automatic logic [31:0] nib_mask(int n);
    return (n >= 8) ? 32'hFFFF_FFFF : ((32'd1 << (4 * n)) - 32'd1);
  endfunction

  function automatic logic [7:0] dig_mask(int n);
    logic [8:0] m;
    m = (9'd1 << n) - 9'd1;
    return m[7:0];
  endfunction

  function automatic logic [31:0] rnd_bcd(int n);
    logic [31:0] b;
    int z;
    b = $urandom;
    z = int'($urandom_range(0, n));
    for (int k = 0; k < 8; k++) if (k >= n - z) b[4*k +: 4] = 4'h0;
    return b & nib_mask(n);
  endfunction

  function automatic vec_t mk(logic [15:0] b, logic [3:0] d, logic l, logic [3:0][6:0] s, logic [3:0] e);
    vec_t v;
    v.bcd = b; v.dpi = d; v.lz = l; v.eseg = s; v.edp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model from the rules: position in frame from elapsed time, blanking from
  // the highest non-zero digit, image swap on the last cycle of each frame.
  task automatic model_step(input int i);
    int n, fl, slot, dig, hi;
    logic [6:0] g;
    logic [7:0] a;
    logic [3:0] v;
    n  = pn[i];
    fl = n * pdv[i];
    if (rst) begin
      m_t[i] = 0; m_sb[i] = '0; m_sd[i] = '0; m_sl[i] = 1'b0;
      m_db[i] = '0; m_dd[i] = '0; m_dl[i] = 1'b0; m_pend[i] = 1'b0;
      m_seg[i] = psl[i] ? 7'h7F : 7'h00;
      m_dp[i]  = psl[i];
      m_an[i]  = pal[i] ? dig_mask(n) : 8'h00;
      m_ft[i]  = 1'b0;
      return;
    end
    slot = m_t[i] % pdv[i];
    dig  = (m_t[i] / pdv[i]) % n;
    hi = -1;
    for (int k = 0; k < n; k++) if (m_db[i][4*k +: 4] != 4'd0) hi = k;
    v = m_db[i][4*dig +: 4];
    g = (m_dl[i] && dig > hi && dig > 0) ? 7'h00 : glyph[v];
    m_seg[i] = psl[i] ? ~g : g;
    m_dp[i]  = m_dd[i][dig] ^ psl[i];
    a = (slot < pgp[i]) ? 8'h00 : (8'h01 << dig);
    m_an[i] = pal[i] ? (~a & dig_mask(n)) : a;
    m_ft[i] = (m_t[i] % fl) == 0;
    if ((m_t[i] % fl) == fl - 1) begin
      m_db[i]   = s_load[i] ? (s_bcd[i] & nib_mask(n)) : m_sb[i];
      m_dd[i]   = s_load[i] ? (s_dp[i] & dig_mask(n)) : m_sd[i];
      m_dl[i]   = s_load[i] ? s_lz[i] : m_sl[i];
      m_pend[i] = 1'b0;
    end else if (s_load[i]) begin
      m_pend[i] = 1'b1;
    end
    if (s_load[i]) begin
      m_sb[i] = s_bcd[i] & nib_mask(n);
      m_sd[i] = s_dp[i] & dig_mask(n);
      m_sl[i] = s_lz[i];
    end
    m_t[i]++;
  endtask

  task automatic check_all();
    logic [17:0] act [3];
    logic [17:0] exp;
    act[0] = {4'h0, an0, seg0, dp0, ft0, pend0};
    act[1] = {7'h0, an1, seg1, dp1, ft1, pend1};
    act[2] = {an2, seg2, dp2, ft2, pend2};
    for (int i = 0; i < 3; i++) begin
      exp = {m_an[i], m_seg[i], m_dp[i], m_ft[i], m_pend[i]};
      checks++;
      if (act[i] !== exp) begin
        errors++;
        $display("FAIL model u%0d {an,seg,dp,ft,pend}: got %h want %h (cycle %0d)", i, act[i], exp, cyc);
      end
    end
    if (!last_rst && an2 == 8'h00) gap0_viol++;
  endtask

  // One clock: background traffic on u1/u2, model step at the edge, check at negedge
  task automatic cycle();
    for (int i = 1; i < 3; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        s_load[i] = 1'b1;
        s_bcd[i]  = rnd_bcd(pn[i]);
        s_dp[i]   = 8'($urandom) & dig_mask(pn[i]);
        s_lz[i]   = 1'($urandom);
      end else begin
        s_load[i] = 1'b0;
      end
    end
    @(posedge clk);
    last_rst = rst;
    for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clk);
    s_load[0] = 1'b0;
    cyc++;
    check_all();
  endtask

  task automatic load0(input logic [15:0] b, input logic [3:0] d, input logic l);
    s_bcd[0] = {16'h0, b}; s_dp[0] = {4'h0, d}; s_lz[0] = l; s_load[0] = 1'b1;
    cycle();
  endtask

  task automatic wait_ft0(input string tag);
    int n;
    n = 0;
    do begin cycle(); n++; end while (ft0 !== 1'b1 && n < 80);
    if (ft0 !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s frame_tick timeout: got %b want 1", tag, ft0);
    end
  endtask

  // Called on the frame_tick cycle; walks the whole frame of u0
  task automatic frame_check(input vec_t v, input string tag);
    int lit [4];
    logic [3:0] sel;
    for (int k = 0; k < 4; k++) lit[k] = 0;
    for (int c = 0; c < 32; c++) begin
      if (c > 0) cycle();
      for (int k = 0; k < 4; k++) begin
        sel = ~(4'b0001 << k);
        if (an0 == sel) begin
          if (lit[k] == 0) begin
            chk($sformatf("%s seg d%0d", tag, k), {25'h0, seg0}, {25'h0, v.eseg[k]});
            chk($sformatf("%s dp d%0d", tag, k), {31'h0, dp0}, {31'h0, v.edp[k]});
          end
          lit[k]++;
        end
      end
    end
    for (int k = 0; k < 4; k++) chk($sformatf("%s lit cycles d%0d", tag, k), lit[k], 6);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, " an"},   {28'h0, an0},   32'hF);
    chk({tag, " seg"},  {25'h0, seg0},  32'h7F);
    chk({tag, " dp"},   {31'h0, dp0},   32'h1);
    chk({tag, " pend"}, {31'h0, pend0}, 32'h0);
    chk({tag, " ft"},   {31'h0, ft0},   32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [7];
    vec_t zeros, v2222, v5678;
    int bad, n;

    tbl[0] = mk(16'h1234, 4'h0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);
    tbl[1] = mk(16'h0070, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'hF);
    tbl[2] = mk(16'h0000, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);
    tbl[3] = mk(16'h0000, 4'h8, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0111);
    tbl[4] = mk(16'h00A5, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'hF);
    tbl[5] = mk(16'h9876, 4'h5, 1'b0, {7'h10, 7'h00, 7'h78, 7'h02}, 4'b1010);
    tbl[6] = mk(16'h0800, 4'h0, 1'b1, {7'h7F, 7'h00, 7'h40, 7'h40}, 4'hF);
    zeros = mk(16'h0000, 4'h0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);
    v2222 = mk(16'h2222, 4'h0, 1'b0, {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF);
    v5678 = mk(16'h5678, 4'h0, 1'b0, {7'h12, 7'h02, 7'h78, 7'h00}, 4'hF);

    for (int i = 0; i < 3; i++) begin
      s_bcd[i] = '0; s_dp[i] = '0; s_lz[i] = 1'b0; s_load[i] = 1'b0;
    end
    rst = 1'b1;
    last_rst = 1'b1;

    // reset held three cycles, then the boot frame shows 0000
    for (int c = 0; c < 3; c++) begin
      cycle();
      reset_checks("reset");
    end
    rst = 1'b0;
    cycle();
    chk("ft after reset", {31'h0, ft0}, 32'h1);
    frame_check(zeros, "boot");

    // directed image table, each loaded at a random point mid-frame
    for (int t = 0; t < 7; t++) begin
      repeat ($urandom_range(0, 20)) cycle();
      load0(tbl[t].bcd, tbl[t].dpi, tbl[t].lz);
      wait_ft0($sformatf("vec%0d", t));
      frame_check(tbl[t], $sformatf("vec%0d", t));
    end

    // double buffer: 1111 superseded by 2222 within the same frame
    wait_ft0("db start");
    cycle(); cycle();
    load0(16'h1111, 4'h0, 1'b0);
    cycle(); cycle();
    load0(16'h2222, 4'h0, 1'b0);
    chk("db pending", {31'h0, pend0}, 32'h1);
    bad = 0; n = 0;
    do begin
      cycle(); n++;
      if (seg0 == 7'h79) bad++;
    end while (ft0 !== 1'b1 && n < 80);
    chk("db 1111 never shown", bad, 0);
    chk("db reached wrap", {31'h0, ft0}, 32'h1);
    frame_check(v2222, "db");

    // load on the wrap cycle itself: bypasses staging
    n = 0;
    while (m_t[0] % 32 != 31 && n < 64) begin cycle(); n++; end
    load0(16'h5678, 4'h0, 1'b0);
    chk("wrap load pending", {31'h0, pend0}, 32'h0);
    wait_ft0("wrap load");
    frame_check(v5678, "wrapload");

    // reset during digit 2 with a staged image pending
    load0(16'h4321, 4'h3, 1'b1);
    n = 0;
    while (((m_t[0] / 8) % 4) != 2 && n < 64) begin cycle(); n++; end
    chk("mr pending before", {31'h0, pend0}, 32'h1);
    rst = 1'b1;
    cycle();
    reset_checks("midreset");
    rst = 1'b0;
    cycle();
    chk("ft after midreset", {31'h0, ft0}, 32'h1);
    frame_check(zeros, "mr0");
    wait_ft0("mr1");
    frame_check(zeros, "mr1");

    // random traffic on all instances, with occasional resets
    for (int c = 0; c < 1200; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        s_bcd[0]  = rnd_bcd(4);
        s_dp[0]   = 8'($urandom) & 8'h0F;
        s_lz[0]   = 1'($urandom);
        s_load[0] = 1'b1;
      end
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    cycle();

    chk("gap0 anodes never all off", gap0_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
